// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared types and encodings for the AHB-Lite to APB bridge
// Bridge FSM states plus AHB transfer-type and response encodings.
package ahb_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_slave_mux.sv
// rtl/apb_slave_mux.sv - slave index to one-hot PSEL and per-slave response select
// Purely combinational; the bridge FSM decides when the select is enabled.
module apb_slave_mux #(
   parameter int NSLV = 4,
   parameter int DW   = 32,
   parameter int IW   = 2
) (
   input  logic                 en_i,
   input  logic [IW-1:0]        idx_i,
   input  logic [NSLV*DW-1:0]   prdata_i,
   input  logic [NSLV-1:0]      pready_i,
   input  logic [NSLV-1:0]      pslverr_i,
   output logic [NSLV-1:0]      psel_o,
   output logic [DW-1:0]        prdata_o,
   output logic                 pready_o,
   output logic                 pslverr_o
);

   always_comb begin
      psel_o    = '0;
      prdata_o  = '0;
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (idx_i == IW'(i)) begin
            psel_o[i] = en_i;
            prdata_o  = prdata_i[i*DW +: DW];
            pready_o  = pready_i[i];
            pslverr_o = pslverr_i[i];
         end
      end
   end

endmodule

// File: rtl/ahb2apb_multislave_bridge.sv
// rtl/ahb2apb_multislave_bridge.sv - AHB-Lite slave to multi-slave APB master bridge
// Decodes the slave from HADDR, sequences SETUP/ACCESS, maps errors to a two-cycle ERROR.
module ahb2apb_multislave_bridge import ahb_apb_pkg::*; #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NSLV    = 4,
   parameter int SLV_LSB = 12,
   parameter int TIMEOUT = 256
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 HSEL,
   input  logic [AW-1:0]        HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [DW-1:0]        HWDATA,
   input  logic                 HREADYIN,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [DW-1:0]        HRDATA,
   output logic [AW-1:0]        PADDR,
   output logic [NSLV-1:0]      PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [DW-1:0]        PWDATA,
   input  logic [NSLV*DW-1:0]   PRDATA,
   input  logic [NSLV-1:0]      PREADY,
   input  logic [NSLV-1:0]      PSLVERR
);

   localparam int IW  = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int FW  = AW - SLV_LSB;
   localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit TO_EN = (TIMEOUT > 0);
   localparam logic [FW-1:0] NSLV_F = FW'(NSLV);
   localparam logic [CW-1:0] TLIM   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic            write_q;
   logic [IW-1:0]   idx_q;
   logic [DW-1:0]   pwdata_q;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            psel_en;
   logic [DW-1:0]   sel_prdata;
   logic            sel_pready;
   logic            sel_pslverr;

   logic            accept;
   logic            unmapped;
   logic            done;
   logic            timeout_hit;
   logic            can_accept;
   state_t          accept_state;

   apb_slave_mux #(.NSLV(NSLV), .DW(DW), .IW(IW)) u_mux (
      .en_i      (psel_en),
      .idx_i     (idx_q),
      .prdata_i  (PRDATA),
      .pready_i  (PREADY),
      .pslverr_i (PSLVERR),
      .psel_o    (PSEL),
      .prdata_o  (sel_prdata),
      .pready_o  (sel_pready),
      .pslverr_o (sel_pslverr)
   );

   // Whole field above SLV_LSB is decoded so addresses past the last slave window error out.
   assign accept       = HSEL && HREADYIN && (HTRANS != HTRANS_IDLE) && (HTRANS != HTRANS_BUSY);
   assign unmapped     = (HADDR[AW-1:SLV_LSB] >= NSLV_F);
   assign done         = (state_q == ST_ACCESS) && sel_pready && !sel_pslverr;
   assign timeout_hit  = TO_EN && (state_q == ST_ACCESS) && !sel_pready && (cnt_q == TLIM);
   assign can_accept   = (state_q == ST_IDLE) || (state_q == ST_ERR2) || done;
   assign accept_state = unmapped ? ST_ERR1 : (HWRITE ? ST_WWAIT : ST_SETUP);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         idx_q    <= '0;
         pwdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (can_accept && accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            idx_q   <= HADDR[SLV_LSB +: IW];
         end
         if (state_q == ST_WWAIT) begin
            pwdata_q <= HWDATA;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_ERR2: state_d = accept ? accept_state : ST_IDLE;
         ST_WWAIT:         state_d = ST_SETUP;
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
         end
         ST_ACCESS: begin
            if (sel_pready) begin
               if (sel_pslverr) state_d = ST_ERR1;
               else             state_d = accept ? accept_state : ST_IDLE;
            end else begin
               if (timeout_hit) state_d = ST_ERR1;
               if (cnt_q != TLIM) cnt_d = cnt_q + CW'(1);
            end
         end
         ST_ERR1:          state_d = ST_ERR2;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = '0;
      psel_en   = 1'b0;
      PENABLE   = 1'b0;
      case (state_q)
         ST_WWAIT: HREADYOUT = 1'b0;
         ST_SETUP: begin
            HREADYOUT = 1'b0;
            psel_en   = 1'b1;
         end
         ST_ACCESS: begin
            psel_en   = 1'b1;
            PENABLE   = 1'b1;
            HREADYOUT = done;
            if (done && !write_q) HRDATA = sel_prdata;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2:  HRESP = HRESP_ERROR;
         default:  HREADYOUT = 1'b1;
      endcase
   end

   assign PADDR  = addr_q;
   assign PWRITE = write_q;
   assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_multislave_bridge.sv
// tb/tb_ahb2apb_multislave_bridge.sv - directed self-checking bench for the AHB to APB bridge
// Drives and samples on the falling clock edge; APB slaves are modelled by PREADY/PSLVERR stimulus.
module tb_ahb2apb_multislave_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NSLV = 4;

   logic                HCLK = 1'b0;
   logic                HRESET;
   logic                HSEL;
   logic [AW-1:0]       HADDR;
   logic [1:0]          HTRANS;
   logic                HWRITE;
   logic [DW-1:0]       HWDATA;
   logic                HREADYIN;
   logic                HREADYOUT;
   logic                HRESP;
   logic [DW-1:0]       HRDATA;
   logic [AW-1:0]       PADDR;
   logic [NSLV-1:0]     PSEL;
   logic                PENABLE;
   logic                PWRITE;
   logic [DW-1:0]       PWDATA;
   logic [NSLV*DW-1:0]  PRDATA;
   logic [NSLV-1:0]     PREADY;
   logic [NSLV-1:0]     PSLVERR;

   int checks = 0;
   int errors = 0;

   int          r_cycles;
   int          r_acc;
   int          r_err1;
   int          r_stable;
   logic        r_done;
   logic        r_resp;
   logic [31:0] r_rdata;
   logic [3:0]  r_psel_seen;
   logic [3:0]  r_first_psel;
   logic        r_first_pen;

   ahb2apb_multislave_bridge #(
      .AW(AW), .DW(DW), .NSLV(NSLV), .SLV_LSB(12), .TIMEOUT(8)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
      .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic go_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      @(negedge HCLK);
   endtask

   // Drives the address phase now, then runs the data phase until HREADYOUT=1.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input int stalls, input logic slverr);
      int st;
      st = stalls;
      HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = 2'b10;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
      PSLVERR = {NSLV{slverr}};
      r_cycles = 0; r_acc = 0; r_err1 = 0; r_stable = 0; r_done = 1'b0;
      r_psel_seen = '0; r_rdata = '0; r_resp = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (PENABLE && st > 0) begin
            PREADY = '0;
            st--;
         end else begin
            PREADY = '1;
         end
         #1;
         r_cycles++;
         if (i == 0) begin
            r_first_psel = PSEL;
            r_first_pen  = PENABLE;
         end
         r_psel_seen |= PSEL;
         if (PENABLE) r_acc++;
         if (PSEL != 0 && PWDATA == wdata && PADDR == addr) r_stable++;
         if (!HREADYOUT && HRESP) r_err1++;
         if (HREADYOUT) begin
            r_done  = 1'b1;
            r_rdata = HRDATA;
            r_resp  = HRESP;
            break;
         end
         @(negedge HCLK);
      end
      chk("xfer_completes", {63'd0, r_done}, 64'd1);
   endtask

   initial begin
      HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HWDATA = '0; HREADYIN = 1'b1; PREADY = '1; PSLVERR = '0;
      PRDATA = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
      repeat (2) @(negedge HCLK);
      chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
      chk("rst_hresp",     {63'd0, HRESP},     64'd0);
      chk("rst_hrdata",    {32'd0, HRDATA},    64'd0);
      chk("rst_psel",      {60'd0, PSEL},      64'd0);
      chk("rst_penable",   {63'd0, PENABLE},   64'd0);
      chk("rst_pwrite",    {63'd0, PWRITE},    64'd0);
      chk("rst_paddr",     {32'd0, PADDR},     64'd0);
      chk("rst_pwdata",    {32'd0, PWDATA},    64'd0);
      HRESET = 1'b0;
      @(negedge HCLK);

      // BUSY transfer: no APB activity, bridge stays ready.
      HSEL = 1'b1; HADDR = 32'h0000_2000; HTRANS = 2'b01; HWRITE = 1'b0;
      @(negedge HCLK);
      chk("busy_psel",   {60'd0, PSEL},      64'd0);
      chk("busy_hready", {63'd0, HREADYOUT}, 64'd1);
      go_idle();

      xfer(32'h0000_2004, 1'b0, 32'h0, 0, 1'b0);
      chk("rd2_cycles", r_cycles,          64'd2);
      chk("rd2_psel",   {60'd0, r_psel_seen}, 64'h4);
      chk("rd2_data",   {32'd0, r_rdata},  64'hC0DE_0002);
      chk("rd2_resp",   {63'd0, r_resp},   64'd0);
      go_idle();
      chk("rd2_after_hrdata", {32'd0, HRDATA}, 64'd0);

      xfer(32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 3, 1'b0);
      chk("wr_dphase_cycles", r_cycles,  64'd6);
      chk("wr_pwdata_stable", r_stable,  64'd5);
      chk("wr_access_cycles", r_acc,     64'd4);
      chk("wr_psel",   {60'd0, r_psel_seen}, 64'h2);
      chk("wr_hrdata", {32'd0, r_rdata},  64'd0);
      chk("wr_pwrite", {63'd0, PWRITE},   64'd1);
      go_idle();

      xfer(32'h0000_0000, 1'b1, 32'h1234_5678, 0, 1'b0);
      chk("b2b_wr_cycles", r_cycles, 64'd3);
      xfer(32'h0000_3000, 1'b0, 32'h0, 0, 1'b0);
      chk("b2b_first_psel", {60'd0, r_first_psel}, 64'h8);
      chk("b2b_first_pen",  {63'd0, r_first_pen},  64'd0);
      chk("b2b_rd_cycles",  r_cycles,              64'd2);
      chk("b2b_rd_data",    {32'd0, r_rdata},      64'hC0DE_0003);
      go_idle();

      xfer(32'h0000_1000, 1'b1, 32'hA5A5_0001, 0, 1'b1);
      chk("slverr_cycles", r_cycles, 64'd5);
      chk("slverr_err1",   r_err1,   64'd1);
      chk("slverr_resp",   {63'd0, r_resp}, 64'd1);
      xfer(32'h0000_2008, 1'b0, 32'h0, 0, 1'b0);
      chk("err2_acc_psel",   {60'd0, r_first_psel}, 64'h4);
      chk("err2_acc_cycles", r_cycles,              64'd2);
      chk("err2_acc_resp",   {63'd0, r_resp},       64'd0);
      go_idle();

      xfer(32'h0000_5000, 1'b0, 32'h0, 0, 1'b0);
      chk("unmap_psel",   {60'd0, r_psel_seen}, 64'd0);
      chk("unmap_cycles", r_cycles,             64'd2);
      chk("unmap_resp",   {63'd0, r_resp},      64'd1);
      chk("unmap_err1",   r_err1,               64'd1);
      go_idle();

      xfer(32'h0000_1000, 1'b0, 32'h0, 100, 1'b0);
      chk("tmo_access_cycles", r_acc,    64'd8);
      chk("tmo_cycles",        r_cycles, 64'd11);
      chk("tmo_resp",          {63'd0, r_resp}, 64'd1);
      go_idle();

      // Reset while the slave is holding the access phase.
      HSEL = 1'b1; HADDR = 32'h0000_2000; HWRITE = 1'b0; HTRANS = 2'b10; PREADY = '1;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge HCLK);
      PREADY = '0;
      #1;
      chk("rstmid_pre_penable", {63'd0, PENABLE}, 64'd1);
      HRESET = 1'b1;
      @(negedge HCLK);
      chk("rstmid_psel",    {60'd0, PSEL},      64'd0);
      chk("rstmid_penable", {63'd0, PENABLE},   64'd0);
      chk("rstmid_hready",  {63'd0, HREADYOUT}, 64'd1);
      chk("rstmid_hresp",   {63'd0, HRESP},     64'd0);
      HRESET = 1'b0; PREADY = '1;
      @(negedge HCLK);

      xfer(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0);
      chk("post_rst_data", {32'd0, r_rdata}, 64'hC0DE_0000);
      go_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
